// File: rtl/level_loader.sv
// Level loader: streams one level's 40 ROM words into shadow tables, commits them on frame_start.
// Latency: 41 cycles from accepted load_req to PEND; tables update on the first frame_start seen in PEND.
// Backpressure: none; load_req is ignored (not queued) while busy, frame_start is ignored outside PEND.
//
// Ports:
//   Clk, reset_n        clock, asynchronous active-low reset
//   load_req, level_id  one-cycle load request and level number (sampled in IDLE only)
//   frame_start         vertical-blank pulse; commits a pending load
//   rom_en, rom_addr    level-ROM read port, address = {level, word}
//   rom_data            ROM read data, one cycle after rom_en/rom_addr
//   busy, done          load in progress / one-cycle commit pulse
//   info_*              committed ground, fence, spike and exit tables
module level_loader #(
  parameter int N_GROUND = 16,
  parameter int N_FENCE  = 16,
  parameter int N_SPIKE  = 6
) (
  input  logic                      Clk,
  input  logic                      reset_n,
  input  logic                      load_req,
  input  logic [2:0]                level_id,
  input  logic                      frame_start,
  output logic                      rom_en,
  output logic [8:0]                rom_addr,
  input  logic [28:0]               rom_data,
  output logic                      busy,
  output logic                      done,
  output logic [N_GROUND-1:0][28:0] info_ground,
  output logic [N_FENCE-1:0][28:0]  info_fence,
  output logic [N_SPIKE-1:0][20:0]  info_spince,
  output logic [1:0][9:0]           info_exit
);

  // Word layout inside a level: ground, fence, spike, then the two exit words.
  localparam int FENCE_BASE = N_GROUND;
  localparam int SPIKE_BASE = N_GROUND + N_FENCE;
  localparam int EXIT_BASE  = SPIKE_BASE + N_SPIKE;
  localparam logic [5:0] LAST_WORD = 6'(EXIT_BASE + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, PEND} state_t;

  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] id_q, id_d;
  logic       rd_vld_q, rd_vld_d;   // a ROM word is arriving this cycle
  logic [5:0] rd_idx_q, rd_idx_d;   // which word is arriving
  logic       done_q, done_d;

  logic [N_GROUND-1:0][28:0] sh_ground_q, sh_ground_d;
  logic [N_FENCE-1:0][28:0]  sh_fence_q, sh_fence_d;
  logic [N_SPIKE-1:0][20:0]  sh_spike_q, sh_spike_d;
  logic [1:0][9:0]           sh_exit_q, sh_exit_d;

  logic [N_GROUND-1:0][28:0] info_ground_q, info_ground_d;
  logic [N_FENCE-1:0][28:0]  info_fence_q, info_fence_d;
  logic [N_SPIKE-1:0][20:0]  info_spike_q, info_spike_d;
  logic [1:0][9:0]           info_exit_q, info_exit_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    id_d          = id_q;
    done_d        = 1'b0;
    rd_vld_d      = (state_q == READ);
    rd_idx_d      = cnt_q;
    sh_ground_d   = sh_ground_q;
    sh_fence_d    = sh_fence_q;
    sh_spike_d    = sh_spike_q;
    sh_exit_d     = sh_exit_q;
    info_ground_d = info_ground_q;
    info_fence_d  = info_fence_q;
    info_spike_d  = info_spike_q;
    info_exit_d   = info_exit_q;

    case (state_q)
      IDLE: begin
        // load_req wins over a coincident frame_start: nothing is pending here.
        if (load_req) begin
          id_d    = level_id;
          cnt_d   = 6'd0;
          state_d = READ;
        end
      end
      READ: begin
        // Counter parks on the last word so rom_addr holds it afterwards.
        if (cnt_q == LAST_WORD) state_d = DRAIN;
        else                    cnt_d   = cnt_q + 6'd1;
      end
      DRAIN: state_d = PEND;
      PEND: begin
        if (frame_start) begin
          info_ground_d = sh_ground_q;
          info_fence_d  = sh_fence_q;
          info_spike_d  = sh_spike_q;
          info_exit_d   = sh_exit_q;
          done_d        = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Route the returning word into its shadow slot; surplus high bits drop off.
    if (rd_vld_q) begin
      for (int i = 0; i < N_GROUND; i++)
        if (rd_idx_q == 6'(i)) sh_ground_d[i] = rom_data;
      for (int i = 0; i < N_FENCE; i++)
        if (rd_idx_q == 6'(FENCE_BASE + i)) sh_fence_d[i] = rom_data;
      for (int i = 0; i < N_SPIKE; i++)
        if (rd_idx_q == 6'(SPIKE_BASE + i)) sh_spike_d[i] = rom_data[20:0];
      for (int i = 0; i < 2; i++)
        if (rd_idx_q == 6'(EXIT_BASE + i)) sh_exit_d[i] = rom_data[9:0];
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      id_q          <= '0;
      rd_vld_q      <= 1'b0;
      rd_idx_q      <= '0;
      done_q        <= 1'b0;
      sh_ground_q   <= '0;
      sh_fence_q    <= '0;
      sh_spike_q    <= '0;
      sh_exit_q     <= '0;
      info_ground_q <= '0;
      info_fence_q  <= '0;
      info_spike_q  <= '0;
      info_exit_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      id_q          <= id_d;
      rd_vld_q      <= rd_vld_d;
      rd_idx_q      <= rd_idx_d;
      done_q        <= done_d;
      sh_ground_q   <= sh_ground_d;
      sh_fence_q    <= sh_fence_d;
      sh_spike_q    <= sh_spike_d;
      sh_exit_q     <= sh_exit_d;
      info_ground_q <= info_ground_d;
      info_fence_q  <= info_fence_d;
      info_spike_q  <= info_spike_d;
      info_exit_q   <= info_exit_d;
    end
  end

  assign rom_en      = (state_q == READ);
  assign rom_addr    = {id_q, cnt_q};
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign info_ground = info_ground_q;
  assign info_fence  = info_fence_q;
  assign info_spince = info_spike_q;
  assign info_exit   = info_exit_q;

endmodule

// File: tb/tb_level_loader.sv
// Bench for level_loader: ROM model, elapsed-cycle reference model, per-cycle compare, directed tests.
// Latency: stimulus driven on negedge, outputs compared 2 time units after each posedge.
// Backpressure: not applicable.
module tb_level_loader;

  logic             Clk;
  logic             reset_n;
  logic             load_req;
  logic [2:0]       level_id;
  logic             frame_start;
  logic             rom_en;
  logic [8:0]       rom_addr;
  logic [28:0]      rom_data;
  logic             busy;
  logic             done;
  logic [15:0][28:0] info_ground;
  logic [15:0][28:0] info_fence;
  logic [5:0][20:0]  info_spince;
  logic [1:0][9:0]   info_exit;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 0;

  level_loader dut (
    .Clk         (Clk),
    .reset_n     (reset_n),
    .load_req    (load_req),
    .level_id    (level_id),
    .frame_start (frame_start),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .busy        (busy),
    .done        (done),
    .info_ground (info_ground),
    .info_fence  (info_fence),
    .info_spince (info_spince),
    .info_exit   (info_exit)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ROM content: level L word n = L*0x80 + n; spike/exit words carry junk in the
  // bits their tables discard, so truncation is exercised.
  function automatic logic [28:0] rom_fn(input logic [2:0] lvl, input int n);
    logic [28:0] w;
    w = 29'(lvl) * 29'h80 + 29'(n);
    if (n >= 32) w = w | 29'h1AA0_0000;
    if (n >= 38) w = w | 29'h0000_1000;
    return w;
  endfunction

  always @(posedge Clk) begin
    if (rom_en) rom_data <= rom_fn(rom_addr[8:6], int'(rom_addr[5:0]));
    else        rom_data <= 29'($urandom);
  end

  // Reference model: counts cycles since an accepted request.
  // 1..40 = issuing word t-1, 41 = capture of last word, 42 = waiting for frame_start.
  int         m_t    = 0;
  logic [2:0] m_lvl  = '0;
  logic [8:0] m_addr = '0;
  bit         m_done = 0;
  bit         m_cv   = 0;      // a level has been committed since reset
  logic [2:0] m_cl   = '0;     // committed level

  always @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      m_t = 0; m_lvl = '0; m_addr = '0; m_done = 0; m_cv = 0; m_cl = '0;
    end else begin
      m_done = 0;
      if (m_t == 0) begin
        if (load_req) begin m_t = 1; m_lvl = level_id; end
      end else if (m_t < 42) begin
        m_t = m_t + 1;
      end else if (frame_start) begin
        m_cv = 1; m_cl = m_lvl; m_done = 1; m_t = 0;
      end
      if (m_t >= 1 && m_t <= 40) m_addr = {m_lvl, 6'(m_t - 1)};
    end
  end

  function automatic logic [15:0][28:0] exp_ground(input bit v, input logic [2:0] l);
    logic [15:0][28:0] r;
    for (int i = 0; i < 16; i++) r[i] = v ? rom_fn(l, i) : '0;
    return r;
  endfunction

  function automatic logic [15:0][28:0] exp_fence(input bit v, input logic [2:0] l);
    logic [15:0][28:0] r;
    for (int i = 0; i < 16; i++) r[i] = v ? rom_fn(l, 16 + i) : '0;
    return r;
  endfunction

  function automatic logic [5:0][20:0] exp_spike(input bit v, input logic [2:0] l);
    logic [5:0][20:0] r;
    logic [28:0] w;
    for (int i = 0; i < 6; i++) begin
      w = rom_fn(l, 32 + i);
      r[i] = v ? w[20:0] : '0;
    end
    return r;
  endfunction

  function automatic logic [1:0][9:0] exp_exit(input bit v, input logic [2:0] l);
    logic [1:0][9:0] r;
    logic [28:0] w;
    for (int i = 0; i < 2; i++) begin
      w = rom_fn(l, 38 + i);
      r[i] = v ? w[9:0] : '0;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Per-cycle comparison against the model.
  always @(posedge Clk) begin
    #2;
    if (cmp_en) begin
      chk("busy",        512'(busy),        512'(m_t != 0));
      chk("done",        512'(done),        512'(m_done));
      chk("rom_en",      512'(rom_en),      512'(m_t >= 1 && m_t <= 40));
      chk("rom_addr",    512'(rom_addr),    512'(m_addr));
      chk("info_ground", 512'(info_ground), 512'(exp_ground(m_cv, m_cl)));
      chk("info_fence",  512'(info_fence),  512'(exp_fence(m_cv, m_cl)));
      chk("info_spince", 512'(info_spince), 512'(exp_spike(m_cv, m_cl)));
      chk("info_exit",   512'(info_exit),   512'(exp_exit(m_cv, m_cl)));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_load(input logic [2:0] lvl);
    @(negedge Clk); load_req = 1'b1; level_id = lvl;
    @(negedge Clk); load_req = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge Clk); frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; load_req = 1'b0; level_id = '0; frame_start = 1'b0;
    tick(3);
    chk("rst_busy",   512'(busy),        512'(0));
    chk("rst_rom_en", 512'(rom_en),      512'(0));
    chk("rst_addr",   512'(rom_addr),    512'(0));
    chk("rst_ground", 512'(info_ground), 512'(0));
    cmp_en  = 1;
    reset_n = 1'b1;

    // Basic load of level 2, commit 100 cycles after the request.
    pulse_load(3'd2);
    level_id = 3'd0;
    chk("t1_addr_first", 512'(rom_addr), 512'(9'h080));
    chk("t1_en_first",   512'(rom_en),   512'(1));
    tick(39);
    chk("t1_addr_last",  512'(rom_addr), 512'(9'h0A7));
    tick(1);
    chk("t1_drain_en",   512'(rom_en),   512'(0));
    chk("t1_drain_busy", 512'(busy),     512'(1));
    chk("t1_drain_addr", 512'(rom_addr), 512'(9'h0A7));
    tick(59);
    chk("t1_pend_info",  512'(info_ground), 512'(0));
    pulse_frame();
    chk("t1_done",       512'(done),           512'(1));
    chk("t1_ground5",    512'(info_ground[5]), 512'(29'h105));
    chk("t1_spike0",     512'(info_spince[0]), 512'(21'h120));
    chk("t1_exit1",      512'(info_exit[1]),   512'(10'h127));
    tick(1);
    chk("t1_done_clr",   512'(done), 512'(0));
    chk("t1_idle_busy",  512'(busy), 512'(0));

    // Early frame_start during READ is ignored; commit after the later pulse.
    reset_n = 1'b0; tick(1); reset_n = 1'b1;
    chk("t2_rst_ground", 512'(info_ground), 512'(0));
    pulse_load(3'd6);
    tick(19);
    pulse_frame();
    chk("t2_early_done", 512'(done),        512'(0));
    chk("t2_early_info", 512'(info_ground), 512'(0));
    tick(499);
    chk("t2_wait_info",  512'(info_exit),   512'(0));
    pulse_frame();
    chk("t2_done",       512'(done),           512'(1));
    chk("t2_ground0",    512'(info_ground[0]), 512'(29'h300));

    // load_req during READ is ignored; level_id change has no effect.
    pulse_load(3'd1);
    tick(9);
    load_req = 1'b1; level_id = 3'd5;
    tick(1);
    load_req = 1'b0;
    chk("t3_addr_hi",    512'(rom_addr[8:6]), 512'(3'b001));
    tick(40);
    pulse_frame();
    chk("t3_done",       512'(done),           512'(1));
    chk("t3_ground3",    512'(info_ground[3]), 512'(29'h083));
    chk("t3_exit0",      512'(info_exit[0]),   512'(10'h0A6));

    // Reset while pending abandons the load.
    pulse_load(3'd3);
    tick(45);
    chk("t4_pend_busy",  512'(busy), 512'(1));
    reset_n = 1'b0; tick(1); reset_n = 1'b1;
    chk("t4_rst_busy",   512'(busy),        512'(0));
    chk("t4_rst_ground", 512'(info_ground), 512'(0));
    pulse_frame();
    chk("t4_no_done",    512'(done),        512'(0));
    tick(1);
    chk("t4_no_done2",   512'(done),        512'(0));
    chk("t4_fence",      512'(info_fence),  512'(0));

    // Request on the first edge after reset release, then back-to-back load.
    reset_n = 1'b0; tick(1);
    reset_n = 1'b1; load_req = 1'b1; level_id = 3'd4;
    tick(1);
    load_req = 1'b0;
    chk("t5_first_busy", 512'(busy),     512'(1));
    chk("t5_first_addr", 512'(rom_addr), 512'(9'h100));
    tick(45);
    pulse_frame();
    chk("t5_done1",      512'(done),           512'(1));
    chk("t5_ground0_l4", 512'(info_ground[0]), 512'(29'h200));
    load_req = 1'b1; level_id = 3'd7; frame_start = 1'b1;
    tick(1);
    load_req = 1'b0; frame_start = 1'b0;
    chk("t5_reload_busy", 512'(busy),           512'(1));
    chk("t5_reload_done", 512'(done),           512'(0));
    chk("t5_reload_addr", 512'(rom_addr),       512'(9'h1C0));
    tick(45);
    chk("t5_hold_l4",     512'(info_ground[0]), 512'(29'h200));
    pulse_frame();
    chk("t5_done2",       512'(done),           512'(1));
    chk("t5_ground0_l7",  512'(info_ground[0]), 512'(29'h380));
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/level_loader.md
LEVEL_LOADER -- requirements
Module: level_loader

Interface
REQ-001 SHALL have parameter N_GROUND, default 16, ground-segment table entries.
REQ-002 SHALL have parameter N_FENCE, default 16, fence-segment table entries.
REQ-003 SHALL have parameter N_SPIKE, default 6, spike table entries; exit table fixed at 2 entries.
REQ-004 SHALL have ports (clock and reset first):
- Clk  in  1  system/pixel clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_req  in  1  one-cycle request to load level level_id.
- level_id  in  3  level number, latched on accepted load_req.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- rom_en  out  1  level-ROM read enable.
- rom_addr  out  9  level-ROM word address = {level_id, word[5:0]}.
- rom_data  in  29  level-ROM read data, valid 1 cycle after rom_en/rom_addr.
- busy  out  1  high while a load is in progress or pending commit.
- done  out  1  one-cycle pulse on the commit edge.
- info_ground  out  29 x N_GROUND  committed ground table.
- info_fence  out  29 x N_FENCE  committed fence table.
- info_spince  out  21 x N_SPIKE  committed spike table.
- info_exit  out  10 x 2  committed exit table.

Function
REQ-005 SHALL implement states IDLE, READ, DRAIN, PEND.
REQ-006 SHALL use level ROM layout per level: words 0-15 ground, 16-31 fence, 32-37 spike (rom_data[20:0]), 38-39 exit (rom_data[9:0]); words 40-63 unused.
REQ-007 In IDLE, load_req=1 SHALL latch level_id, clear word counter to 0, enter READ next cycle.
REQ-008 In READ, each cycle SHALL drive rom_en=1 and rom_addr={latched_id, k} for k=0..39, incrementing k every cycle.
REQ-009 Data returned the cycle after address k SHALL be written into shadow entry k (ground, fence, spike or exit per REQ-006); unused upper bits discarded.
REQ-010 After issuing k=39, SHALL enter DRAIN for exactly one cycle (rom_en=0) to capture word 39, then enter PEND.
REQ-011 Load from accepted load_req to entering PEND SHALL take exactly 41 cycles (40 READ + 1 DRAIN).
REQ-012 In PEND, frame_start=1 SHALL copy all shadow entries to the info_* outputs on that edge, pulse done for the following cycle, return to IDLE.
REQ-013 info_* outputs SHALL change only on a commit edge or reset; never mid-frame, never partially.
REQ-014 frame_start in IDLE, READ or DRAIN SHALL be ignored; commit waits for the next frame_start seen in PEND.
REQ-015 load_req in any state other than IDLE SHALL be ignored (not queued); level_id changes outside IDLE SHALL have no effect.
REQ-016 load_req and frame_start in the same IDLE cycle: load_req SHALL be accepted, frame_start ignored.
REQ-017 busy SHALL be 1 in READ, DRAIN, PEND and 0 in IDLE; done SHALL be 0 except the single cycle after commit.
REQ-018 rom_en SHALL be 0 outside READ; rom_addr SHALL hold its last value when rom_en=0.
REQ-019 Word counter SHALL be 6 bits and SHALL never exceed 39 in READ.

Reset
REQ-020 reset_n=0 SHALL asynchronously force state IDLE, counter 0, latched id 0, rom_en=0, rom_addr=0, busy=0, done=0, all shadow and info_* entries to 0.
REQ-021 Reset mid-load (READ/DRAIN/PEND) SHALL abandon the load; info_* SHALL read 0 and no done pulse SHALL occur.
REQ-022 After reset_n deasserts, first load_req SHALL be accepted on the first rising edge with reset_n=1.

Verification
REQ-023 Basic load: ROM word n of level 2 = n+0x100, load_req with level_id=2, frame_start 100 cycles later -> rom_addr 0x080..0x0A7 on 40 consecutive cycles, busy=1 for 41+wait cycles, done one cycle after frame_start, info_ground[5]=0x105, info_spince[0]=0x120, info_exit[1]=0x127.
REQ-024 Early frame_start: pulse frame_start at cycle 20 of READ and again 500 cycles later -> no commit at cycle 20; commit and done only after the second pulse; info_* unchanged (0) before it.
REQ-025 Ignored request: during READ of level 1 assert load_req with level_id=5 -> rom_addr upper bits stay 3'b001 throughout; committed tables hold level 1 data.
REQ-026 Reset in PEND: complete READ/DRAIN of level 3, assert reset_n=0 for 1 cycle before frame_start -> busy=0, all info_* = 0, no done on subsequent frame_start.
REQ-027 Back-to-back: load level 4, commit, load_req the cycle done is high, then frame_start -> second load accepted (IDLE), tables switch from level 4 to new level only on second commit edge.
